vector_list_player: RTL and testbench

- Display-list sequencer on the command side of the vector control path; drives its `x`, `y`, `jump`, `draw` inputs and honours its `ready` output.
- Fetches 32-bit vector entries from a synchronous-read frame memory, decodes each one and issues a single-cycle jump or draw command only when the downstream path is ready.
- Replays the frame continuously (loop mode) or once, and reports frame completion.

---
 rtl/vector_pkg.sv | 33 +++
 rtl/vector_entry_decode.sv | 27 ++
 rtl/vector_list_player.sv | 177 +++++++++++++++++
 tb/tb_vector_list_player.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
`default_nettype none
// vector_pkg: entry field layout, opcodes and sequencer states shared by the vector list player.
// Revision 1.0
package vector_pkg;

  localparam int COORD_W = 12;
  localparam int ENTRY_W = 32;

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam int OP_HI = 31;
  localparam int OP_LO = 30;
  localparam int X_HI  = 27;
  localparam int X_LO  = 16;
  localparam int Y_HI  = 11;
  localparam int Y_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_DATA  = 3'd2,
    ST_DECODE     = 3'd3,
    ST_WAIT_READY = 3'd4,
    ST_ISSUE      = 3'd5,
    ST_HOLDOFF    = 3'd6,
    ST_FRAME_END  = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vector_entry_decode.sv
`default_nettype none
// vector_entry_decode: splits a 32-bit display-list entry into opcode, coordinates and class flags.
// Revision 1.0
module vector_entry_decode
  import vector_pkg::*;
(
  input  logic [ENTRY_W-1:0] entry,
  output logic [1:0]         opcode,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               is_cmd,
  output logic               is_end
);

  logic unused_bits;

  assign opcode = entry[OP_HI:OP_LO];
  assign x      = entry[X_HI:X_LO];
  assign y      = entry[Y_HI:Y_LO];
  assign is_cmd = (opcode == OP_JUMP) || (opcode == OP_DRAW);
  assign is_end = (opcode == OP_END);

  // Reserved fields carry no meaning.
  assign unused_bits = ^{entry[29:28], entry[15:12]};

endmodule
`default_nettype wire

// File: rtl/vector_list_player.sv
`default_nettype none
// vector_list_player: fetches vector entries from frame memory and issues jump/draw commands to the vector path.
// Revision 1.0
module vector_list_player
  import vector_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [ADDR_W-1:0]  frame_base,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [31:0]        mem_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  input  logic               ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  addr_inc;
  logic [ENTRY_W-1:0] entry;
  logic [CNT_W-1:0]   cnt;
  logic               first;
  logic               stop_pending;
  logic               wrap;
  logic               stop_now;
  logic               wrap_now;

  logic [1:0]         dec_op;
  logic [COORD_W-1:0] dec_x;
  logic [COORD_W-1:0] dec_y;
  logic               dec_is_cmd;
  logic               dec_is_end;

  vector_entry_decode u_decode (
    .entry  (entry),
    .opcode (dec_op),
    .x      (dec_x),
    .y      (dec_y),
    .is_cmd (dec_is_cmd),
    .is_end (dec_is_end)
  );

  assign addr_inc = addr + ADDR_W'(1);
  assign wrap_now = (addr_inc == start_addr);
  assign stop_now = stop_pending | stop;
  assign mem_addr = addr;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    jump       = 1'b0;
    draw       = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:       if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        mem_rd_en  = 1'b1;
        state_next = ST_WAIT_DATA;
      end
      ST_WAIT_DATA:  if (cnt == RD_LAST) state_next = ST_DECODE;
      ST_DECODE: begin
        if (dec_is_end) begin
          frame_done = 1'b1;
          state_next = ST_FRAME_END;
        end else if (dec_is_cmd) begin
          state_next = ST_WAIT_READY;
        end else if (wrap_now) begin
          frame_done = 1'b1;
          state_next = ST_FRAME_END;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_WAIT_READY: if (ready) state_next = ST_ISSUE;
      ST_ISSUE: begin
        // The beam position is unknown at frame start, so the first command is always a move.
        draw       = (dec_op == OP_DRAW) && !first;
        jump       = !draw;
        state_next = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          if (wrap) begin
            frame_done = 1'b1;
            state_next = ST_FRAME_END;
          end else if (stop_now) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_FRAME_END:  state_next = (loop && !stop_now) ? ST_FETCH : ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr         <= '0;
      start_addr   <= '0;
      entry        <= '0;
      cnt          <= '0;
      first        <= 1'b1;
      stop_pending <= 1'b0;
      wrap         <= 1'b0;
      x            <= '0;
      y            <= '0;
    end else begin
      cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);

      if (state != ST_IDLE && state_next == ST_IDLE)
        stop_pending <= 1'b0;
      else if (stop && (state != ST_IDLE || start))
        stop_pending <= 1'b1;

      // Coordinates are loaded on entry to ISSUE so they are valid alongside the pulse.
      if (state == ST_WAIT_READY && ready) begin
        x <= dec_x;
        y <= dec_y;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr       <= frame_base;
            start_addr <= frame_base;
            first      <= 1'b1;
            wrap       <= 1'b0;
          end
        end
        ST_WAIT_DATA: if (cnt == RD_LAST) entry <= mem_data;
        ST_DECODE:    if (!dec_is_cmd && !dec_is_end) addr <= addr_inc;
        ST_ISSUE: begin
          first <= 1'b0;
          addr  <= addr_inc;
          wrap  <= wrap_now;
        end
        ST_FRAME_END: begin
          if (state_next == ST_FETCH) begin
            addr       <= frame_base;
            start_addr <= frame_base;
            first      <= 1'b1;
            wrap       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_list_player.sv
`default_nettype none
`timescale 1ns/1ps
// tb_vector_list_player: scoreboard bench for the vector list player.
module tb_vector_list_player;

  localparam int RD_LAT  = 1;
  localparam int HOLDOFF = 2;
  localparam logic [1:0] K_JUMP = 2'd0;
  localparam logic [1:0] K_DRAW = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] x;
    logic [11:0] y;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset;
  logic a_start, a_stop, a_loop, a_ready;
  logic [9:0] a_base, a_addr;
  logic a_rd, a_jump, a_draw, a_busy, a_done;
  logic [31:0] a_data;
  logic [11:0] a_x, a_y;
  logic b_start, b_stop, b_loop, b_ready;
  logic [3:0] b_base, b_addr;
  logic b_rd, b_jump, b_draw, b_busy, b_done;
  logic [31:0] b_data;
  logic [11:0] b_x, b_y;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:15];
  always @(posedge clk) if (a_rd) a_data <= mem_a[a_addr];
  always @(posedge clk) if (b_rd) b_data <= mem_b[b_addr];

  vector_list_player #(.ADDR_W(10), .RD_LAT(RD_LAT), .HOLDOFF(HOLDOFF)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .loop(a_loop),
    .frame_base(a_base), .mem_addr(a_addr), .mem_rd_en(a_rd), .mem_data(a_data),
    .x(a_x), .y(a_y), .jump(a_jump), .draw(a_draw), .ready(a_ready),
    .busy(a_busy), .frame_done(a_done)
  );

  vector_list_player #(.ADDR_W(4), .RD_LAT(RD_LAT), .HOLDOFF(HOLDOFF)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .loop(b_loop),
    .frame_base(b_base), .mem_addr(b_addr), .mem_rd_en(b_rd), .mem_data(b_data),
    .x(b_x), .y(b_y), .jump(b_jump), .draw(b_draw), .ready(b_ready),
    .busy(b_busy), .frame_done(b_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic [11:0] ex, input logic [11:0] ey);
    ev_t e;
    e.kind = k; e.x = ex; e.y = ey;
    return e;
  endfunction

  ev_t qa[$];
  ev_t qb[$];
  ev_t ea, eb;
  int a_pulses = 0, a_dones = 0, a_rd_cnt = 0, a_base_fetch = 0, a_last_pulse = 0, a_gap = 0;
  int b_pulses = 0;

  always @(negedge clk) begin
    if (a_rd === 1'b1) begin
      a_rd_cnt++;
      if (a_addr == 10'h3F0) a_base_fetch++;
    end
    if (a_jump === 1'b1 && a_draw === 1'b1) check("a_jump_draw_both", {a_jump, a_draw}, 2'b01);
    if (a_jump === 1'b1 || a_draw === 1'b1) begin
      a_gap = cyc - a_last_pulse;
      a_last_pulse = cyc;
      a_pulses++;
      if (qa.size() == 0) check("a_unexpected_cmd", {a_jump, a_draw}, 0);
      else begin
        ea = qa.pop_front();
        check("a_cmd_kind", a_draw ? K_DRAW : K_JUMP, ea.kind);
        check("a_cmd_xy", {a_x, a_y}, {ea.x, ea.y});
      end
    end
    if (a_done === 1'b1) begin
      a_dones++;
      if (qa.size() == 0) check("a_unexpected_done", a_done, 0);
      else begin
        ea = qa.pop_front();
        check("a_done_kind", K_DONE, ea.kind);
      end
    end
  end

  always @(negedge clk) begin
    if (b_jump === 1'b1 || b_draw === 1'b1 || b_done === 1'b1) begin
      if (b_jump === 1'b1 || b_draw === 1'b1) b_pulses++;
      if (qb.size() == 0) check("b_unexpected_out", {b_jump, b_draw, b_done}, 0);
      else begin
        eb = qb.pop_front();
        check("b_kind", b_done ? K_DONE : (b_draw ? K_DRAW : K_JUMP), eb.kind);
        if (!b_done) check("b_cmd_xy", {b_x, b_y}, {eb.x, eb.y});
      end
    end
  end

  task automatic wait_idle(input bit sel, input int maxc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sel ? b_busy : a_busy) && n < maxc);
    check(name, sel ? b_busy : a_busy, 0);
  endtask

  task automatic pulse_start_a(input bit with_stop);
    @(negedge clk);
    a_start = 1'b1;
    a_stop  = with_stop;
    @(negedge clk);
    a_start = 1'b0;
    a_stop  = 1'b0;
  endtask

  task automatic load_basic();
    mem_a[0] = 32'h4100_0200;
    mem_a[1] = 32'h4300_0200;
    mem_a[2] = 32'h8000_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int p0, rd0, d0, bf0, rc, n;
    reset = 1'b1;
    a_start = 0; a_stop = 0; a_loop = 0; a_ready = 1; a_base = '0;
    b_start = 0; b_stop = 0; b_loop = 0; b_ready = 1; b_base = '0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 32'h8000_0000;
    for (int i = 0; i < 16; i++) mem_b[i] = {2'b01, 2'b00, 12'(i), 4'h0, 12'(15 - i)};
    repeat (3) @(negedge clk);
    check("rst_mem_addr", a_addr, 0);
    check("rst_rd_en", a_rd, 0);
    check("rst_xy", {a_x, a_y}, 0);
    check("rst_jump_draw", {a_jump, a_draw}, 0);
    check("rst_busy", a_busy, 0);
    check("rst_frame_done", a_done, 0);
    reset = 1'b0;

    // Basic list: first DRAW becomes a JUMP.
    load_basic();
    qa.push_back(mk(K_JUMP, 12'h100, 12'h200));
    qa.push_back(mk(K_DRAW, 12'h300, 12'h200));
    qa.push_back(mk(K_DONE, 0, 0));
    d0 = a_dones; p0 = a_pulses;
    pulse_start_a(1'b0);
    wait_idle(1'b0, 100, "basic_idle");
    check("basic_pulses", a_pulses - p0, 2);
    check("basic_dones", a_dones - d0, 1);
    check("cmd_spacing", (a_gap >= 1 + HOLDOFF + RD_LAT + 2) && (a_gap <= 1 + HOLDOFF + RD_LAT + 3), 1);
    check("basic_queue_empty", qa.size(), 0);

    // Downstream not ready for 20 cycles.
    a_ready = 1'b0;
    qa.push_back(mk(K_JUMP, 12'h100, 12'h200));
    qa.push_back(mk(K_DRAW, 12'h300, 12'h200));
    qa.push_back(mk(K_DONE, 0, 0));
    p0 = a_pulses; rd0 = a_rd_cnt;
    pulse_start_a(1'b0);
    repeat (20) @(negedge clk);
    check("hold_no_pulse", a_pulses - p0, 0);
    check("hold_single_fetch", a_rd_cnt - rd0, 1);
    check("hold_xy_kept", {a_x, a_y}, {12'h300, 12'h200});
    a_ready = 1'b1;
    rc = cyc;
    n = 0;
    while (a_pulses == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_release_latency", a_last_pulse - rc, 1);
    wait_idle(1'b0, 100, "hold_idle");
    check("hold_queue_empty", qa.size(), 0);

    // NOP between JUMP and DRAW.
    mem_a[0] = 32'h0010_0020;
    mem_a[1] = 32'hC555_0AAA;
    mem_a[2] = 32'h4040_0050;
    mem_a[3] = 32'h8000_0000;
    qa.push_back(mk(K_JUMP, 12'h010, 12'h020));
    qa.push_back(mk(K_DRAW, 12'h040, 12'h050));
    qa.push_back(mk(K_DONE, 0, 0));
    p0 = a_pulses;
    pulse_start_a(1'b0);
    wait_idle(1'b0, 100, "nop_idle");
    check("nop_pulses", a_pulses - p0, 2);
    check("nop_queue_empty", qa.size(), 0);

    // Loop mode at a high base, three frames.
    mem_a[10'h3F0] = 32'h47FF_0001;
    mem_a[10'h3F1] = 32'h8000_0000;
    a_base = 10'h3F0;
    a_loop = 1'b1;
    for (int f = 0; f < 3; f++) begin
      qa.push_back(mk(K_JUMP, 12'h7FF, 12'h001));
      qa.push_back(mk(K_DONE, 0, 0));
    end
    d0 = a_dones; bf0 = a_base_fetch;
    pulse_start_a(1'b0);
    n = 0;
    while (a_dones - d0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    a_loop = 1'b0;
    wait_idle(1'b0, 50, "loop_idle");
    check("loop_dones", a_dones - d0, 3);
    check("loop_base_fetches", a_base_fetch - bf0, 3);
    check("loop_queue_empty", qa.size(), 0);
    a_base = '0;

    // No END entry: full address wrap on the 4-bit instance.
    qb.push_back(mk(K_JUMP, 12'd0, 12'd15));
    for (int i = 1; i < 16; i++) qb.push_back(mk(K_DRAW, 12'(i), 12'(15 - i)));
    qb.push_back(mk(K_DONE, 0, 0));
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    wait_idle(1'b1, 400, "wrap_idle");
    check("wrap_pulses", b_pulses, 16);
    check("wrap_queue_empty", qb.size(), 0);

    // Stop while waiting for ready: command still issues, then idle.
    load_basic();
    a_ready = 1'b0;
    qa.push_back(mk(K_JUMP, 12'h100, 12'h200));
    p0 = a_pulses; rd0 = a_rd_cnt;
    pulse_start_a(1'b0);
    repeat (8) @(negedge clk);
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    a_ready = 1'b1;
    wait_idle(1'b0, 50, "stop_idle");
    check("stop_busy_drop", cyc - a_last_pulse, 1 + HOLDOFF);
    check("stop_pulses", a_pulses - p0, 1);
    check("stop_no_refetch", a_rd_cnt - rd0, 1);
    check("stop_queue_empty", qa.size(), 0);

    // Start and stop in the same idle cycle.
    qa.push_back(mk(K_JUMP, 12'h100, 12'h200));
    p0 = a_pulses;
    pulse_start_a(1'b1);
    wait_idle(1'b0, 50, "startstop_idle");
    check("startstop_pulses", a_pulses - p0, 1);
    check("startstop_queue_empty", qa.size(), 0);

    // Reset during the ISSUE cycle.
    a_ready = 1'b0;
    qa.push_back(mk(K_JUMP, 12'h100, 12'h200));
    pulse_start_a(1'b0);
    repeat (8) @(negedge clk);
    a_ready = 1'b1;
    @(negedge clk);
    check("rst_issue_pulse_seen", a_jump, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_issue_jump_draw", {a_jump, a_draw}, 0);
    check("rst_issue_xy", {a_x, a_y}, 0);
    check("rst_issue_busy", a_busy, 0);
    check("rst_issue_rd_en", a_rd, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_issue_stays_idle", a_busy, 0);
    check("final_queue_empty", qa.size() + qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
